sha2_msg_scheduler: RTL

SHA2_MSG_SCHEDULER -- requirements
Module: sha2_msg_scheduler

---
 rtl/sha2_msg_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message schedule generator: streams W0..W(ROUNDS-1) for one 16-word block.
// Define SHA2_SCHED_ABORT_EN to add the i_abort port.
module sha2_msg_scheduler #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [16*WORD_W-1:0]    i_block,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [WORD_W-1:0]       o_w,
    output logic                    o_w_valid,
    input  logic                    i_w_ready,
    output logic [6:0]              o_idx,
    output logic                    o_last,
    output logic                    o_busy
`ifdef SHA2_SCHED_ABORT_EN
    ,
    input  logic                    i_abort
`endif
);

    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = 7;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  win [NWORDS];
    logic [IDX_W-1:0]   idx;

    logic [WORD_W-1:0]  x0;
    logic [WORD_W-1:0]  x1;
    logic [WORD_W-1:0]  s0;
    logic [WORD_W-1:0]  s1;
    logic [WORD_W-1:0]  w_new;
    logic               abort_c;
    logic               hs_c;

`ifdef SHA2_SCHED_ABORT_EN
    assign abort_c = i_abort;
`else
    assign abort_c = 1'b0;
`endif

    assign x0 = win[1];
    assign x1 = win[14];

    // Small-sigma functions differ between the 32-bit and 64-bit SHA-2 families
    generate
        if (WORD_W == 64) begin : g_sig64
            assign s0 = {x0[0:0],  x0[63:1]}  ^ {x0[7:0],  x0[63:8]}  ^ (x0 >> 7);
            assign s1 = {x1[18:0], x1[63:19]} ^ {x1[60:0], x1[63:61]} ^ (x1 >> 6);
        end else begin : g_sig32
            assign s0 = {x0[6:0],  x0[31:7]}  ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
            assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);
        end
    endgenerate

    assign w_new = s1 + win[9] + s0 + win[0];

    assign o_ready = (state == IDLE) && !abort_c;
    assign o_busy  = (state == EMIT);
    assign o_w     = win[0];
    assign o_idx   = idx;
    assign hs_c    = o_w_valid && i_w_ready;

    // Window slides down on each handshake; the head word is always the current Wt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            o_w_valid <= 1'b0;
            o_last    <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                win[i] <= '0;
            end
        end else if (abort_c) begin
            state     <= IDLE;
            idx       <= '0;
            o_w_valid <= 1'b0;
            o_last    <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state     <= EMIT;
                        idx       <= '0;
                        o_w_valid <= 1'b1;
                        o_last    <= (ROUNDS == 1);
                        for (int i = 0; i < NWORDS; i++) begin
                            win[i] <= i_block[(NWORDS-1-i)*WORD_W +: WORD_W];
                        end
                    end
                end
                EMIT: begin
                    if (hs_c) begin
                        if (o_last) begin
                            state     <= IDLE;
                            idx       <= '0;
                            o_w_valid <= 1'b0;
                            o_last    <= 1'b0;
                            for (int i = 0; i < NWORDS; i++) begin
                                win[i] <= '0;
                            end
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            o_last <= (idx == IDX_W'(ROUNDS - 2));
                            for (int i = 0; i < NWORDS - 1; i++) begin
                                win[i] <= win[i+1];
                            end
                            win[NWORDS-1] <= w_new;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
